downsample_engine: RTL

//  2x2 box-filter downsampler: walks the source image in DRAM, reads each 2x2 block,

---
 rtl/downsample_engine_if.sv | 19 +
 rtl/downsample_engine.sv | 135 +++++++++++++
 2 files changed

// File: rtl/downsample_engine_if.sv
// DRAM-side bus of the downsample engine: address, strobes, write data and read data.
// Read data comes back one cycle after a read strobe, and a write commits at the edge that ends its cycle.
interface downsample_engine_if;
    logic [15:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    modport master (
        output mem_addr, mem_read, mem_write, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_read, mem_write, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/downsample_engine.sv
// 2x2 box-filter downsampler: reads each 2x2 source block from DRAM and writes back one averaged pixel.
// Latency is 6 cycles per output pixel, and done pulses in cycle 6N+1 after start is accepted.
// There is no backpressure because DRAM is fixed-latency; define DS_ROUND_EN to round half up instead of truncating.
module downsample_engine #(
    parameter int          IMG_W_LOG2 = 8,
    parameter int          IMG_H_LOG2 = 8,
    parameter logic [15:0] SRC_BASE   = 16'h0,
    parameter logic [15:0] DST_BASE   = 16'h0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    downsample_engine_if.master        mem
);

    localparam int          CW         = IMG_W_LOG2 - 1;
    localparam int          RW         = IMG_H_LOG2 - 1;
    localparam logic [CW-1:0] COL_LAST = '1;
    localparam logic [RW-1:0] ROW_LAST = '1;
    localparam logic [15:0] ROW_STRIDE = 16'(1) << IMG_W_LOG2;

    typedef enum logic [2:0] {
        S_IDLE, S_R0, S_R1, S_R2, S_R3, S_CAP, S_WR, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [9:0]    sum_q, sum_d;
    logic          last_pix;
    logic [15:0]   blk_src;
    logic [15:0]   blk_dst;
    logic [7:0]    avg;

    assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign blk_src  = SRC_BASE + (16'(row_q) << (IMG_W_LOG2 + 1)) + (16'(col_q) << 1);
    assign blk_dst  = DST_BASE + (16'(row_q) << (IMG_W_LOG2 - 1)) + 16'(col_q);

`ifdef DS_ROUND_EN
    logic [9:0] sum_rnd;
    // Worst case 1020 + 2 still fits in 10 bits, so the rounding add cannot wrap.
    assign sum_rnd = sum_q + 10'd2;
    assign avg     = sum_rnd[9:2];
`else
    assign avg     = sum_q[9:2];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_R0;
            S_R0:    state_d = S_R1;
            S_R1:    state_d = S_R2;
            S_R2:    state_d = S_R3;
            S_R3:    state_d = S_CAP;
            S_CAP:   state_d = S_WR;
            S_WR:    state_d = last_pix ? S_DONE : S_R0;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Each read's data arrives in the following state, so R1..CAP accumulate the previous read.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        sum_d = sum_q;
        case (state_q)
            S_R1, S_R2, S_R3, S_CAP: sum_d = sum_q + {2'b00, mem.mem_rdata};
            S_WR: begin
                sum_d = '0;
                col_d = col_q + CW'(1);
                if (col_q == COL_LAST) row_d = row_q + RW'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_o        = 1'b0;
        done_o        = 1'b0;
        mem.mem_addr  = 16'h0;
        mem.mem_read  = 1'b0;
        mem.mem_write = 1'b0;
        mem.mem_wdata = 8'h0;
        case (state_q)
            S_R0: begin
                busy_o       = 1'b1;
                mem.mem_read = 1'b1;
                mem.mem_addr = blk_src;
            end
            S_R1: begin
                busy_o       = 1'b1;
                mem.mem_read = 1'b1;
                mem.mem_addr = blk_src + 16'd1;
            end
            S_R2: begin
                busy_o       = 1'b1;
                mem.mem_read = 1'b1;
                mem.mem_addr = blk_src + ROW_STRIDE;
            end
            S_R3: begin
                busy_o       = 1'b1;
                mem.mem_read = 1'b1;
                mem.mem_addr = blk_src + ROW_STRIDE + 16'd1;
            end
            S_CAP: busy_o = 1'b1;
            S_WR: begin
                busy_o        = 1'b1;
                mem.mem_write = 1'b1;
                mem.mem_addr  = blk_dst;
                mem.mem_wdata = avg;
            end
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

endmodule
